// File: rtl/ex_muldiv_ctl.sv
// ex_muldiv_ctl: iterative multiply/divide sequencer for the Execute stage.
// Owns the architectural HI/LO registers, runs a WIDTH-iteration shift-add
// multiply or restoring divide, and stalls the front of the pipe via busy.
// Build option: define EX_MULDIV_DIV_EN to include the divider and DIV/DIVU.
module ex_muldiv_ctl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [1:0]       mt_we,
    input  logic             mf_sel,
    output logic [WIDTH-1:0] mf_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic               neg_q;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] acc;

    logic               signed_op;
    logic               op_ok;
    logic               accept;
    logic [WIDTH-1:0]   rs_abs;
    logic [WIDTH-1:0]   rt_abs;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [2*WIDTH-1:0] step_next;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

`ifdef EX_MULDIV_DIV_EN
    logic               is_div;
    logic               neg_r;
    logic               dz;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
`endif

    // Signed ops work on magnitudes; the sign is restored in FIX.
    assign signed_op = op[0];
    assign rs_abs    = (signed_op && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign rt_abs    = (signed_op && rt_val[WIDTH-1]) ? -rt_val : rt_val;

`ifdef EX_MULDIV_DIV_EN
    assign op_ok = 1'b1;
`else
    assign op_ok = ~op[1];
`endif
    assign accept = (state == IDLE) && start && op_ok;

    // Multiply step: add the multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole accumulator right.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};
    assign prod_fix = neg_q ? -acc : acc;

`ifdef EX_MULDIV_DIV_EN
    // Divide step: upper half is the partial remainder, lower half shifts the
    // dividend out and the quotient in. The shifted remainder is one bit wider
    // so the trial subtract cannot overflow.
    assign div_shift = acc[2*WIDTH-1:WIDTH-1];
    assign div_ge    = (div_shift >= {1'b0, operand});
    assign div_diff  = div_shift[WIDTH-1:0] - operand;
    assign div_next  = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                              : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    assign quo_fix   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`else
    assign div_by_zero = 1'b0;
`endif

    // Pick the per-cycle iteration result and the HI/LO values written in FIX.
    always_comb begin
        step_next = mul_next;
        fix_hi    = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo    = prod_fix[WIDTH-1:0];
`ifdef EX_MULDIV_DIV_EN
        if (is_div) begin
            step_next = div_next;
            fix_hi    = rem_fix;
            fix_lo    = quo_fix;
        end
`endif
    end

    // Sequencer FSM with registered busy/done/div_by_zero and HI/LO storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            neg_q   <= 1'b0;
            operand <= '0;
            acc     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
`ifdef EX_MULDIV_DIV_EN
            is_div      <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            div_by_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef EX_MULDIV_DIV_EN
            div_by_zero <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        busy    <= 1'b1;
                        count   <= '0;
                        state   <= CALC;
                        neg_q   <= signed_op & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                        operand <= rs_abs;
                        acc     <= {{WIDTH{1'b0}}, rt_abs};
`ifdef EX_MULDIV_DIV_EN
                        is_div <= op[1];
                        neg_r  <= signed_op & rs_val[WIDTH-1];
                        dz     <= 1'b0;
                        if (op[1]) begin
                            operand <= rt_abs;
                            acc     <= {{WIDTH{1'b0}}, rs_abs};
                            if (rt_val == '0) begin
                                // Divide by zero skips the loop: HI gets the
                                // raw dividend, LO all ones, no sign fix-up.
                                dz    <= 1'b1;
                                neg_q <= 1'b0;
                                neg_r <= 1'b0;
                                acc   <= {rs_val, {WIDTH{1'b1}}};
                                state <= FIX;
                            end
                        end
`endif
                    end else if (!start) begin
                        if (mt_we[1]) hi <= rs_val;
                        if (mt_we[0]) lo <= rs_val;
                    end
                end
                CALC: begin
                    acc   <= step_next;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
`ifdef EX_MULDIV_DIV_EN
                    div_by_zero <= dz;
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mf_data = mf_sel ? hi : lo;

endmodule

// File: tb/tb_ex_muldiv_ctl.sv
// Testbench for ex_muldiv_ctl: scoreboard of expected HI/LO/div_by_zero
// results pushed at issue time and popped when done is observed.
// Divide scenarios are compiled only when EX_MULDIV_DIV_EN is defined.
module tb_ex_muldiv_ctl;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic [1:0]   mt_we;
    logic         mf_sel;
    logic [W-1:0] mf_data;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;
    logic [W-1:0] cur_hi;
    logic [W-1:0] cur_lo;

    ex_muldiv_ctl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .mt_we      (mt_we),
        .mf_sel     (mf_sel),
        .mf_data    (mf_data),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hi         (hi),
        .lo         (lo)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Issue one operation and follow it to done (or until max_cyc cycles).
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] mtv, input int max_cyc,
                          output int done_cyc, output int busy_cnt, output logic [W-1:0] mid_lo,
                          output logic [W-1:0] ohi, output logic [W-1:0] olo, output logic odz);
        done_cyc = -1;
        busy_cnt = 0;
        mid_lo   = '0;
        ohi      = '0;
        olo      = '0;
        odz      = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        mt_we  = mtv;
        @(posedge clk);
        #1;
        start  = 1'b0;
        op     = ~o;
        rs_val = $urandom;
        rt_val = $urandom;
        for (int n = 1; n <= max_cyc; n++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (n == 5) mid_lo = lo;
            if (done) begin
                done_cyc = n;
                ohi = hi;
                olo = lo;
                odz = div_by_zero;
                break;
            end
        end
        mt_we = 2'b00;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
        mt_we = 2'b00; mf_sel = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        checks++; if (div_by_zero !== 1'b0) begin failures++; $display("[TB] FAIL reset_dz got=%b exp=0", div_by_zero); end
        checks++; if (hi !== '0) begin failures++; $display("[TB] FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== '0) begin failures++; $display("[TB] FAIL reset_lo got=%h exp=0", lo); end
        rst = 1'b0;
        cur_hi = '0;
        cur_lo = '0;
        @(negedge clk);
    endtask

    task automatic test_multu;
        int dc, bc; logic [W-1:0] ml, oh, ol; logic odz; exp_t e;
        e.hi = 32'hFFFFFFFE; e.lo = 32'h00000001; e.dz = 1'b0;
        sb.push_back(e);
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 40, dc, bc, ml, oh, ol, odz);
        e = sb.pop_front();
        checks++; if (dc !== 34) begin failures++; $display("[TB] FAIL multu_done_cycle got=%0d exp=34", dc); end
        checks++; if (bc !== 33) begin failures++; $display("[TB] FAIL multu_busy_cycles got=%0d exp=33", bc); end
        checks++; if (oh !== e.hi) begin failures++; $display("[TB] FAIL multu_hi got=%h exp=%h", oh, e.hi); end
        checks++; if (ol !== e.lo) begin failures++; $display("[TB] FAIL multu_lo got=%h exp=%h", ol, e.lo); end
        cur_hi = e.hi; cur_lo = e.lo;
    endtask

    task automatic test_mult;
        int dc, bc; logic [W-1:0] ml, oh, ol; logic odz; exp_t e;
        e.hi = 32'hFFFFFFFF; e.lo = 32'hFFFFFFEB; e.dz = 1'b0;
        sb.push_back(e);
        run_op(2'b01, -32'sd3, 32'd7, 2'b00, 40, dc, bc, ml, oh, ol, odz);
        mf_sel = 1'b0;
        #1;
        e = sb.pop_front();
        checks++; if (dc !== 34) begin failures++; $display("[TB] FAIL mult_done_cycle got=%0d exp=34", dc); end
        checks++; if (oh !== e.hi) begin failures++; $display("[TB] FAIL mult_hi got=%h exp=%h", oh, e.hi); end
        checks++; if (ol !== e.lo) begin failures++; $display("[TB] FAIL mult_lo got=%h exp=%h", ol, e.lo); end
        checks++; if (mf_data !== e.lo) begin failures++; $display("[TB] FAIL mflo got=%h exp=%h", mf_data, e.lo); end
        mf_sel = 1'b1;
        #1;
        checks++; if (mf_data !== e.hi) begin failures++; $display("[TB] FAIL mfhi got=%h exp=%h", mf_data, e.hi); end
        mf_sel = 1'b0;
        cur_hi = e.hi; cur_lo = e.lo;
    endtask

`ifdef EX_MULDIV_DIV_EN
    task automatic test_div;
        int dc, bc; logic [W-1:0] ml, oh, ol; logic odz; exp_t e;
        e.hi = 32'hFFFFFFFF; e.lo = 32'hFFFFFFFD; e.dz = 1'b0;
        sb.push_back(e);
        run_op(2'b11, -32'sd7, 32'd2, 2'b00, 40, dc, bc, ml, oh, ol, odz);
        e = sb.pop_front();
        checks++; if (dc !== 34) begin failures++; $display("[TB] FAIL div_done_cycle got=%0d exp=34", dc); end
        checks++; if (oh !== e.hi) begin failures++; $display("[TB] FAIL div_hi got=%h exp=%h", oh, e.hi); end
        checks++; if (ol !== e.lo) begin failures++; $display("[TB] FAIL div_lo got=%h exp=%h", ol, e.lo); end
        checks++; if (odz !== e.dz) begin failures++; $display("[TB] FAIL div_dz got=%b exp=%b", odz, e.dz); end
        e.hi = 32'h00000000; e.lo = 32'h80000000; e.dz = 1'b0;
        sb.push_back(e);
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 2'b00, 40, dc, bc, ml, oh, ol, odz);
        e = sb.pop_front();
        checks++; if (oh !== e.hi) begin failures++; $display("[TB] FAIL div_ovf_hi got=%h exp=%h", oh, e.hi); end
        checks++; if (ol !== e.lo) begin failures++; $display("[TB] FAIL div_ovf_lo got=%h exp=%h", ol, e.lo); end
        cur_hi = e.hi; cur_lo = e.lo;
    endtask
`endif

    task automatic test_div_by_zero;
        int dc, bc; logic [W-1:0] ml, oh, ol; logic odz;
`ifdef EX_MULDIV_DIV_EN
        exp_t e;
        e.hi = 32'h00000064; e.lo = 32'hFFFFFFFF; e.dz = 1'b1;
        sb.push_back(e);
        run_op(2'b10, 32'd100, 32'd0, 2'b00, 10, dc, bc, ml, oh, ol, odz);
        e = sb.pop_front();
        checks++; if (dc !== 2) begin failures++; $display("[TB] FAIL dz_done_cycle got=%0d exp=2", dc); end
        checks++; if (bc !== 1) begin failures++; $display("[TB] FAIL dz_busy_cycles got=%0d exp=1", bc); end
        checks++; if (odz !== e.dz) begin failures++; $display("[TB] FAIL dz_flag got=%b exp=%b", odz, e.dz); end
        checks++; if (oh !== e.hi) begin failures++; $display("[TB] FAIL dz_hi got=%h exp=%h", oh, e.hi); end
        checks++; if (ol !== e.lo) begin failures++; $display("[TB] FAIL dz_lo got=%h exp=%h", ol, e.lo); end
        cur_hi = e.hi; cur_lo = e.lo;
`else
        run_op(2'b10, 32'd100, 32'd0, 2'b00, 8, dc, bc, ml, oh, ol, odz);
        checks++; if (dc !== -1) begin failures++; $display("[TB] FAIL nodiv_done got=%0d exp=-1", dc); end
        checks++; if (bc !== 0) begin failures++; $display("[TB] FAIL nodiv_busy got=%0d exp=0", bc); end
        checks++; if (hi !== cur_hi) begin failures++; $display("[TB] FAIL nodiv_hi got=%h exp=%h", hi, cur_hi); end
        checks++; if (lo !== cur_lo) begin failures++; $display("[TB] FAIL nodiv_lo got=%h exp=%h", lo, cur_lo); end
        checks++; if (div_by_zero !== 1'b0) begin failures++; $display("[TB] FAIL nodiv_dz got=%b exp=0", div_by_zero); end
`endif
    endtask

    task automatic test_mt;
        int dc, bc; logic [W-1:0] ml, oh, ol; logic odz; exp_t e;
        @(negedge clk); mt_we = 2'b10; rs_val = 32'h1234;
        @(negedge clk); mt_we = 2'b00;
        checks++; if (hi !== 32'h1234) begin failures++; $display("[TB] FAIL mthi got=%h exp=00001234", hi); end
        checks++; if (lo !== cur_lo) begin failures++; $display("[TB] FAIL mthi_lo_kept got=%h exp=%h", lo, cur_lo); end
        mt_we = 2'b01; rs_val = 32'h5678;
        @(negedge clk); mt_we = 2'b00;
        checks++; if (lo !== 32'h5678) begin failures++; $display("[TB] FAIL mtlo got=%h exp=00005678", lo); end
        checks++; if (hi !== 32'h1234) begin failures++; $display("[TB] FAIL mtlo_hi_kept got=%h exp=00001234", hi); end
        mt_we = 2'b11; rs_val = 32'hABCD;
        @(negedge clk); mt_we = 2'b00;
        checks++; if (hi !== 32'hABCD || lo !== 32'hABCD) begin
            failures++; $display("[TB] FAIL mt_both got=%h/%h exp=0000abcd/0000abcd", hi, lo);
        end
        // start together with mt_we, and mt_we held through busy
        e.hi = 32'h0; e.lo = 32'h33; e.dz = 1'b0;
        sb.push_back(e);
        run_op(2'b00, 32'h11, 32'h3, 2'b11, 40, dc, bc, ml, oh, ol, odz);
        e = sb.pop_front();
        checks++; if (ml !== 32'hABCD) begin failures++; $display("[TB] FAIL mt_while_busy lo got=%h exp=0000abcd", ml); end
        checks++; if (dc !== 34) begin failures++; $display("[TB] FAIL mt_start_done got=%0d exp=34", dc); end
        checks++; if (oh !== e.hi || ol !== e.lo) begin
            failures++; $display("[TB] FAIL mt_start_result got=%h/%h exp=%h/%h", oh, ol, e.hi, e.lo);
        end
        cur_hi = e.hi; cur_lo = e.lo;
    endtask

    task automatic test_reset_mid;
        int dc, bc, ndone; logic [W-1:0] ml, oh, ol; logic odz; exp_t e;
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs_val = -32'sd5; rt_val = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (hi !== '0 || lo !== '0) begin failures++; $display("[TB] FAIL rstmid_hilo got=%h/%h exp=0/0", hi, lo); end
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++; if (ndone !== 0) begin failures++; $display("[TB] FAIL rstmid_no_done got=%0d exp=0", ndone); end
        e.hi = 32'h0; e.lo = 32'd30; e.dz = 1'b0;
        sb.push_back(e);
        run_op(2'b00, 32'd5, 32'd6, 2'b00, 40, dc, bc, ml, oh, ol, odz);
        e = sb.pop_front();
        checks++; if (dc !== 34) begin failures++; $display("[TB] FAIL rstmid_restart_done got=%0d exp=34", dc); end
        checks++; if (ol !== e.lo || oh !== e.hi) begin
            failures++; $display("[TB] FAIL rstmid_restart_result got=%h/%h exp=%h/%h", oh, ol, e.hi, e.lo);
        end
        cur_hi = e.hi; cur_lo = e.lo;
    endtask

    task automatic test_back_to_back;
        int dc, bc; logic [W-1:0] ml, oh, ol, a, b; logic odz; exp_t e;
        logic [1:0] o; logic [2*W-1:0] p; logic signed [2*W-1:0] sa, sbv, q, r;
        for (int i = 0; i < 6; i++) begin
`ifdef EX_MULDIV_DIV_EN
            o = 2'($urandom_range(0, 3));
`else
            o = 2'($urandom_range(0, 1));
`endif
            a = $urandom; b = $urandom;
            if (i == 0) a = 32'h7FFFFFFF;
            if (o[1] && b == '0) b = 32'd1;
            sa = $signed(a); sbv = $signed(b);
            e.dz = 1'b0;
            case (o)
                2'b00: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
                2'b01: begin q = sa * sbv; e.hi = q[63:32]; e.lo = q[31:0]; end
                2'b10: begin e.lo = a / b; e.hi = a % b; end
                default: begin q = sa / sbv; r = sa % sbv; e.lo = q[31:0]; e.hi = r[31:0]; end
            endcase
            sb.push_back(e);
            run_op(o, a, b, 2'b00, 40, dc, bc, ml, oh, ol, odz);
            e = sb.pop_front();
            checks++; if (oh !== e.hi || ol !== e.lo || dc !== 34) begin
                failures++;
                $display("[TB] FAIL b2b_%0d op=%b a=%h b=%h got=%h/%h@%0d exp=%h/%h@34", i, o, a, b, oh, ol, dc, e.hi, e.lo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
`ifdef EX_MULDIV_DIV_EN
        test_div();
`endif
        test_div_by_zero();
        test_mt();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
